// File: rtl/scs8hd_xoracc_pkg.sv
// Shared constants and helpers for the XOR accumulator and its reduction tree.
`timescale 1ns/1ps
package scs8hd_xoracc_pkg;

   localparam logic XORACC_PASS = 1'b0;
   localparam logic XORACC_ACC  = 1'b1;

   // Increment that sticks at 2^cntw-1; callers truncate the result to cntw bits (cntw <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned cntw);
      logic [32:0] max_val;
      max_val = (33'd1 << cntw) - 33'd1;
      return (33'(val) >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/scs8hd_xor_reduce.sv
// Combinational bitwise XOR of LANES operands of WIDTH bits each.
`timescale 1ns/1ps
module scs8hd_xor_reduce #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LANES = 2
) (
   input  logic [LANES*WIDTH-1:0] data_i,
   output logic [WIDTH-1:0]       res_o
);

   always_comb begin
      res_o = '0;
      for (int k = 0; k < LANES; k++) begin
         res_o = res_o ^ data_i[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/scs8hd_xoracc.sv
// Registered multi-lane XOR with per-beat pass mode and per-frame accumulate mode.
// Optional parity output P is enabled by defining SCS8HD_XORACC_PARITY_EN.
`timescale 1ns/1ps
module scs8hd_xoracc
   import scs8hd_xoracc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LANES = 2,
   parameter int unsigned CNTW  = 8
) (
   input  logic                   CLK,
   input  logic                   RESETB,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [LANES*WIDTH-1:0] DATA,
   input  logic                   MODE,
   input  logic                   LAST,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [WIDTH-1:0]       X,
   output logic [CNTW-1:0]        CNT
`ifdef SCS8HD_XORACC_PARITY_EN
   ,
   output logic                   P
`endif
);

   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNTW-1:0]  acnt_q, acnt_d, acnt_inc;
   logic [WIDTH-1:0] x_q, x_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             accept;

   scs8hd_xor_reduce #(
      .WIDTH(WIDTH),
      .LANES(LANES)
   ) u_reduce (
      .data_i(DATA),
      .res_o (r)
   );

   assign IN_READY = !valid_q || OUT_READY;
   assign accept   = IN_VALID && IN_READY;
   assign acnt_inc = CNTW'(sat_inc(32'(acnt_q), CNTW));

   always_comb begin
      acc_d   = acc_q;
      acnt_d  = acnt_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (valid_q && OUT_READY) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         if (MODE == XORACC_PASS) begin
            // Pass beats leave the open frame untouched.
            x_d     = r;
            cnt_d   = CNTW'(1);
            valid_d = 1'b1;
         end else if (LAST) begin
            x_d     = acc_q ^ r;
            cnt_d   = acnt_inc;
            valid_d = 1'b1;
            acc_d   = '0;
            acnt_d  = '0;
         end else begin
            acc_d  = acc_q ^ r;
            acnt_d = acnt_inc;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         acc_q   <= '0;
         acnt_q  <= '0;
         x_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         acnt_q  <= acnt_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign X         = x_q;
   assign CNT       = cnt_q;
   assign OUT_VALID = valid_q;

`ifdef SCS8HD_XORACC_PARITY_EN
   logic p_q;

   // x_d equals x_q unless a result loads, so tracking ^x_d every cycle keeps P aligned with X.
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         p_q <= 1'b0;
      end else begin
         p_q <= ^x_d;
      end
   end

   assign P = p_q;
`endif

endmodule

// File: tb/tb_scs8hd_xoracc.sv
// Scoreboard bench for scs8hd_xoracc: default DUT plus a CNTW=2 copy fed identical stimulus.
`timescale 1ns/1ps
module tb_scs8hd_xoracc;

   logic        CLK = 1'b0;
   logic        RESETB = 1'b0;
   logic        IN_VALID = 1'b0;
   logic [15:0] DATA = '0;
   logic        MODE = 1'b0;
   logic        LAST = 1'b0;
   logic        OUT_READY = 1'b0;
   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [7:0]  x, x2;
   logic [7:0]  cnt;
   logic [1:0]  cnt2;
`ifdef SCS8HD_XORACC_PARITY_EN
   logic        p, p2;
`endif

   always #5 CLK = ~CLK;

   scs8hd_xoracc #(.WIDTH(8), .LANES(2), .CNTW(8)) dut (
      .CLK(CLK), .RESETB(RESETB), .IN_VALID(IN_VALID), .IN_READY(in_ready), .DATA(DATA),
      .MODE(MODE), .LAST(LAST), .OUT_VALID(out_valid), .OUT_READY(OUT_READY), .X(x), .CNT(cnt)
`ifdef SCS8HD_XORACC_PARITY_EN
      , .P(p)
`endif
   );

   scs8hd_xoracc #(.WIDTH(8), .LANES(2), .CNTW(2)) dut_sat (
      .CLK(CLK), .RESETB(RESETB), .IN_VALID(IN_VALID), .IN_READY(in_ready2), .DATA(DATA),
      .MODE(MODE), .LAST(LAST), .OUT_VALID(out_valid2), .OUT_READY(OUT_READY), .X(x2),
      .CNT(cnt2)
`ifdef SCS8HD_XORACC_PARITY_EN
      , .P(p2)
`endif
   );

   typedef struct {
      logic [7:0] x;
      int         n;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_acc = '0;
   int         m_n = 0;
   int         ntests = 0;
   int         nfail = 0;
   bit         rand_rdy = 0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (!ok) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   // Reference model: frame-level XOR and beat count, straight from the operating rules.
   task automatic model_accept(input logic [15:0] d, input logic m, input logic l);
      logic [7:0] r;
      exp_t e;
      r = d[7:0] ^ d[15:8];
      if (!m) begin
         e.x = r; e.n = 1; q.push_back(e);
      end else begin
         m_acc = m_acc ^ r;
         m_n++;
         if (l) begin
            e.x = m_acc; e.n = m_n; q.push_back(e);
            m_acc = '0; m_n = 0;
         end
      end
   endtask

   task automatic beat(input logic [15:0] d, input logic m, input logic l);
      bit done;
      done = 0;
      DATA = d; MODE = m; LAST = l; IN_VALID = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge CLK);
         if (in_ready) begin
            model_accept(d, m, l);
            done = 1;
         end
      end
      chk(done, "beat_accept_bound", 32'(done), 32'd1);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESETB = 1'b0;
      #1;
      chk(out_valid === 1'b0 && out_valid2 === 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
      chk(x === 8'h00 && x2 === 8'h00, "rst_x", 32'(x), 32'd0);
      chk(cnt === 8'h00 && cnt2 === 2'd0, "rst_cnt", 32'(cnt), 32'd0);
      chk(in_ready === 1'b1 && in_ready2 === 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SCS8HD_XORACC_PARITY_EN
      chk(p === 1'b0 && p2 === 1'b0, "rst_p", 32'(p), 32'd0);
`endif
      q.delete();
      m_acc = '0;
      m_n = 0;
      @(posedge CLK); #1;
      RESETB = 1'b1;
   endtask

   always @(posedge CLK) begin
      #1;
      if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
   end

   // Monitor: checks handshake behaviour every cycle and pops the scoreboard on each transfer.
   logic       exp_valid = 1'b0;
   logic       held = 1'b0;
   logic [7:0] held_x = '0;
   logic [7:0] held_cnt = '0;
   always @(negedge CLK) begin
      if (!RESETB) begin
         exp_valid = 1'b0;
         held = 1'b0;
      end else begin
         exp_t e;
         logic ld;
         chk(out_valid === exp_valid, "out_valid", 32'(out_valid), 32'(exp_valid));
         chk(out_valid2 === exp_valid, "out_valid_sat", 32'(out_valid2), 32'(exp_valid));
         chk(in_ready === (!exp_valid || OUT_READY), "in_ready", 32'(in_ready),
             32'(!exp_valid || OUT_READY));
         if (held) begin
            chk(x === held_x && cnt === held_cnt, "hold_stable", {cnt, x}, {held_cnt, held_x});
         end
         if (exp_valid && OUT_READY) begin
            if (q.size() == 0) begin
               chk(1'b0, "unexpected_output", 32'(x), 32'hx);
            end else begin
               e = q.pop_front();
               chk(x === e.x, "x", 32'(x), 32'(e.x));
               chk(32'(cnt) == 32'(sat(e.n, 255)), "cnt", 32'(cnt), 32'(sat(e.n, 255)));
               chk(x2 === e.x, "x_sat", 32'(x2), 32'(e.x));
               chk(32'(cnt2) == 32'(sat(e.n, 3)), "cnt_sat", 32'(cnt2), 32'(sat(e.n, 3)));
`ifdef SCS8HD_XORACC_PARITY_EN
               chk(p === ^e.x, "parity", 32'(p), 32'(^e.x));
`endif
            end
         end
         held     = exp_valid && !OUT_READY;
         held_x   = x;
         held_cnt = cnt;
         ld = IN_VALID && (!exp_valid || OUT_READY) && (!MODE || LAST);
         if (ld) exp_valid = 1'b1;
         else if (exp_valid && OUT_READY) exp_valid = 1'b0;
      end
   end

   initial begin
      @(posedge CLK); #1;
      do_reset();
      OUT_READY = 1'b1;

      // Pass: A5 ^ 0F = AA
      beat(16'hA50F, 1'b0, 1'b0);
      // Three-beat frame, R = 01, 02, 04
      beat(16'h0001, 1'b1, 1'b0);
      beat(16'h0301, 1'b1, 1'b0);
      beat(16'h0400, 1'b1, 1'b1);
      idle(2);

      // Backpressure: result pending for 4 cycles, then drain and accept together
      OUT_READY = 1'b0;
      beat(16'h1234, 1'b0, 1'b0);
      fork
         beat(16'hC33C, 1'b0, 1'b0);
         begin
            repeat (4) @(posedge CLK);
            #1;
            OUT_READY = 1'b1;
         end
      join
      idle(2);

      // Pass beat interleaved inside an open frame
      beat(16'h0003, 1'b1, 1'b0);
      beat(16'h00FF, 1'b0, 1'b0);
      beat(16'h0000, 1'b1, 1'b1);

      // Six-beat frame saturates the CNTW=2 counter
      for (int i = 0; i < 6; i++) beat(16'($urandom), 1'b1, i == 5);
      idle(2);

      // Reset mid-frame with a held pass result
      beat(16'h0101, 1'b1, 1'b0);
      beat(16'h0202, 1'b1, 1'b0);
      OUT_READY = 1'b0;
      beat(16'h5555, 1'b0, 1'b0);
      do_reset();
      OUT_READY = 1'b1;
      beat(16'h0010, 1'b1, 1'b1);
      idle(2);

      // Random traffic with random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         beat(16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      beat(16'($urandom), 1'b1, 1'b1);
      rand_rdy = 0;
      idle(1);
      OUT_READY = 1'b1;
      idle(4);
      chk(q.size() == 0, "scoreboard_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
